// File: rtl/controller_fsm_mem.sv
// Instruction controller for the 16-bit datapath CPU: fetch, decode, ALU ops,
// LDR/STR sequencing with MEM_LAT-cycle reads, HALT and optional single-step.
module controller_fsm_mem #(
  parameter int MEM_LAT     = 1,
  parameter bit SINGLE_STEP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [2:0] nsel,
  output logic [3:0] vsel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic [4:0] state_dbg
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  typedef enum logic [4:0] {
    S_RST, S_WAIT, S_IF, S_UPDPC, S_DECODE, S_GETA, S_GETB, S_EXEC, S_WRC,
    S_CMP, S_WIMM, S_ADDR, S_LDADDR, S_MRD, S_GETD, S_PASSD, S_MWR, S_HALT
  } state_t;

  localparam state_t DONE_ST = SINGLE_STEP ? S_WAIT : S_IF;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          cnt_last;

  assign cnt_last  = (cnt == CNT_LAST);
  assign state_dbg = state;

  // cnt restarts on entry to a memory-read state and counts cycles spent there.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RST;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if ((state_n == S_IF || state_n == S_MRD) && state_n != state)
        cnt <= '0;
      else if (state == S_IF || state == S_MRD)
        cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_RST:    state_n = SINGLE_STEP ? S_WAIT : S_IF;
      S_WAIT:   if (s) state_n = S_IF;
      S_IF:     if (cnt_last) state_n = S_UPDPC;
      S_UPDPC:  state_n = S_DECODE;
      S_DECODE: begin
        state_n = DONE_ST;
        if (opcode == 3'b101)
          state_n = (op == 2'b11) ? S_GETB : S_GETA;
        else if (opcode == 3'b110 && op == 2'b10)
          state_n = S_WIMM;
        else if (opcode == 3'b110 && op == 2'b00)
          state_n = S_GETB;
        else if ((opcode == 3'b011 || opcode == 3'b100) && op == 2'b00)
          state_n = S_GETA;
        else if (opcode == 3'b111)
          state_n = S_HALT;
      end
      S_GETA:   state_n = (opcode == 3'b101) ? S_GETB : S_ADDR;
      S_GETB:   state_n = (opcode == 3'b101 && op == 2'b01) ? S_CMP : S_EXEC;
      S_EXEC:   state_n = S_WRC;
      S_WRC:    state_n = DONE_ST;
      S_CMP:    state_n = DONE_ST;
      S_WIMM:   state_n = DONE_ST;
      S_ADDR:   state_n = S_LDADDR;
      S_LDADDR: state_n = (opcode == 3'b011) ? S_MRD : S_GETD;
      S_MRD:    if (cnt_last) state_n = DONE_ST;
      S_GETD:   state_n = S_PASSD;
      S_PASSD:  state_n = S_MWR;
      S_MWR:    state_n = DONE_ST;
      S_HALT:   state_n = S_HALT;
      default:  state_n = S_RST;
    endcase
  end

  always_comb begin
    w         = 1'b0;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    nsel      = 3'b000;
    vsel      = 4'b0000;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = 2'b00;
    case (state)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_WAIT, S_HALT: w = 1'b1;
      S_IF: begin
        addr_sel = 1'b1;
        mem_cmd  = 2'b01;
        load_ir  = cnt_last;
      end
      S_UPDPC: load_pc = 1'b1;
      S_GETA: begin
        nsel  = 3'b100;
        loada = 1'b1;
      end
      S_GETB: begin
        nsel  = 3'b001;
        loadb = 1'b1;
      end
      S_EXEC: begin
        loadc = 1'b1;
        asel  = (opcode == 3'b110);
      end
      S_WRC: begin
        nsel  = 3'b010;
        vsel  = 4'b0001;
        write = 1'b1;
      end
      S_CMP:  loads = 1'b1;
      S_WIMM: begin
        nsel  = 3'b100;
        vsel  = 4'b0100;
        write = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LDADDR: load_addr = 1'b1;
      // Read data is only valid on the final latency cycle, so writeback waits for it.
      S_MRD: begin
        mem_cmd = 2'b01;
        if (cnt_last) begin
          nsel  = 3'b010;
          vsel  = 4'b1000;
          write = 1'b1;
        end
      end
      S_GETD: begin
        nsel  = 3'b010;
        loadb = 1'b1;
      end
      S_PASSD: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_MWR:   mem_cmd = 2'b10;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controller_fsm_mem.sv
// Bench for controller_fsm_mem: three parameter configurations, per-instruction
// expected output traces queued by the driver and compared by a negedge monitor.
module tb_controller_fsm_mem;

  localparam int NCFG = 3;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit ss_of(input int g);
    return (g == 2);
  endfunction

  // Packed output word: {w, write, loada, loadb, loadc, loads, asel, bsel,
  // nsel[2:0], vsel[3:0], load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd[1:0]}
  localparam logic [21:0] O_W      = 22'd1 << 21;
  localparam logic [21:0] O_WRITE  = 22'd1 << 20;
  localparam logic [21:0] O_LOADA  = 22'd1 << 19;
  localparam logic [21:0] O_LOADB  = 22'd1 << 18;
  localparam logic [21:0] O_LOADC  = 22'd1 << 17;
  localparam logic [21:0] O_LOADS  = 22'd1 << 16;
  localparam logic [21:0] O_ASEL   = 22'd1 << 15;
  localparam logic [21:0] O_BSEL   = 22'd1 << 14;
  localparam logic [21:0] N_RN     = 22'd4 << 11;
  localparam logic [21:0] N_RD     = 22'd2 << 11;
  localparam logic [21:0] N_RM     = 22'd1 << 11;
  localparam logic [21:0] V_C      = 22'd1 << 7;
  localparam logic [21:0] V_IMM    = 22'd4 << 7;
  localparam logic [21:0] V_MD     = 22'd8 << 7;
  localparam logic [21:0] O_LD_IR  = 22'd1 << 6;
  localparam logic [21:0] O_LD_PC  = 22'd1 << 5;
  localparam logic [21:0] O_RST_PC = 22'd1 << 4;
  localparam logic [21:0] O_LD_AD  = 22'd1 << 3;
  localparam logic [21:0] O_ASRC   = 22'd1 << 2;
  localparam logic [21:0] M_RD     = 22'd1;
  localparam logic [21:0] M_WR     = 22'd2;
  localparam logic [21:0] RST_W    = O_RST_PC | O_LD_PC;

  logic        clk = 1'b0;
  logic        rst;
  int          cur;
  logic        s;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [21:0] obs [NCFG];
  logic [4:0]  dbg [NCFG];

  logic [21:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    logic w, write, loada, loadb, loadc, loads, asel, bsel;
    logic load_ir, load_pc, reset_pc, load_addr, addr_sel;
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic [1:0] mem_cmd;
    logic [4:0] state_dbg;

    controller_fsm_mem #(.MEM_LAT(lat_of(g)), .SINGLE_STEP(ss_of(g))) u_dut (
      .clk(clk), .reset(rst || (cur != g)), .s(s), .opcode(opcode), .op(op),
      .w(w), .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
      .loads(loads), .asel(asel), .bsel(bsel), .nsel(nsel), .vsel(vsel),
      .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
      .load_addr(load_addr), .addr_sel(addr_sel), .mem_cmd(mem_cmd),
      .state_dbg(state_dbg)
    );

    assign obs[g] = {w, write, loada, loadb, loadc, loads, asel, bsel, nsel, vsel,
                     load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd};
    assign dbg[g] = state_dbg;
  end

  // Monitor: one expected word per cycle, compared away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [21:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs[cur] !== e) begin
        errors++;
        $display("FAIL outputs cfg=%0d state=%0d t=%0t got=%b exp=%b",
                 cur, dbg[cur], $time, obs[cur], e);
      end
    end
  end

  task automatic push(input logic [21:0] v);
    exp_q.push_back(v);
  endtask

  task automatic push_fetch(input int lat);
    for (int i = 0; i < lat; i++)
      push(O_ASRC | M_RD | ((i == lat - 1) ? O_LD_IR : 22'd0));
    push(O_LD_PC);
    push(22'd0);
  endtask

  // Reference model: cycle-by-cycle outputs of one instruction, from fetch to done.
  task automatic expect_instr(input int lat, input logic [2:0] opc, input logic [1:0] o,
                              output int n);
    int start;
    start = exp_q.size();
    push_fetch(lat);
    if (opc == 3'b101) begin
      if (o != 2'b11) push(N_RN | O_LOADA);
      push(N_RM | O_LOADB);
      if (o == 2'b01) push(O_LOADS);
      else begin
        push(O_LOADC);
        push(N_RD | V_C | O_WRITE);
      end
    end else if (opc == 3'b110 && o == 2'b10) begin
      push(N_RN | V_IMM | O_WRITE);
    end else if (opc == 3'b110 && o == 2'b00) begin
      push(N_RM | O_LOADB);
      push(O_LOADC | O_ASEL);
      push(N_RD | V_C | O_WRITE);
    end else if ((opc == 3'b011 || opc == 3'b100) && o == 2'b00) begin
      push(N_RN | O_LOADA);
      push(O_BSEL | O_LOADC);
      push(O_LD_AD);
      if (opc == 3'b011) begin
        for (int i = 0; i < lat; i++)
          push(M_RD | ((i == lat - 1) ? (N_RD | V_MD | O_WRITE) : 22'd0));
      end else begin
        push(N_RD | O_LOADB);
        push(O_ASEL | O_LOADC);
        push(M_WR);
      end
    end
    n = exp_q.size() - start;
  endtask

  // Advance n cycles with random s pulses, which must never matter outside WAIT.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      s = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    s = 1'b0;
  endtask

  task automatic start_cfg(input int g);
    @(posedge clk);
    #1;
    cur = g;
    rst = 1'b1;
    push(RST_W);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(RST_W);
    @(posedge clk);
    #1;
  endtask

  // In single-step mode the DUT sits in WAIT until a one-cycle s pulse.
  task automatic begin_instr(input int g);
    int k;
    if (ss_of(g)) begin
      k = $urandom_range(1, 4);
      s = 1'b0;
      repeat (k) begin
        push(O_W);
        @(posedge clk);
        #1;
      end
      s = 1'b1;
      push(O_W);
      @(posedge clk);
      #1;
      s = 1'b0;
    end
  endtask

  task automatic do_instr(input int g, input logic [2:0] opc, input logic [1:0] o);
    int n;
    opcode = opc;
    op     = o;
    begin_instr(g);
    expect_instr(lat_of(g), opc, o, n);
    run(n);
  endtask

  task automatic rand_instr(input int g);
    logic [2:0] opc;
    logic [1:0] o;
    case ($urandom_range(0, 9))
      0: begin opc = 3'b101; o = 2'b00; end
      1: begin opc = 3'b101; o = 2'b01; end
      2: begin opc = 3'b101; o = 2'b10; end
      3: begin opc = 3'b101; o = 2'b11; end
      4: begin opc = 3'b110; o = 2'b10; end
      5: begin opc = 3'b110; o = 2'b00; end
      6: begin opc = 3'b011; o = 2'b00; end
      7: begin opc = 3'b100; o = 2'b00; end
      default: begin
        opc = 3'($urandom_range(0, 6));
        o   = 2'($urandom_range(0, 3));
      end
    endcase
    do_instr(g, opc, o);
  endtask

  task automatic reset_mid_ldr(input int g);
    int lat;
    lat    = lat_of(g);
    opcode = 3'b011;
    op     = 2'b00;
    begin_instr(g);
    push_fetch(lat);
    push(N_RN | O_LOADA);
    push(O_BSEL | O_LOADC);
    push(O_LD_AD);
    push(M_RD | ((lat == 1) ? (N_RD | V_MD | O_WRITE) : 22'd0));
    run(lat + 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(RST_W);
    @(posedge clk);
    #1;
  endtask

  task automatic do_halt(input int g);
    opcode = 3'b111;
    op     = 2'($urandom_range(0, 3));
    begin_instr(g);
    push_fetch(lat_of(g));
    repeat (20) push(O_W);
    run(lat_of(g) + 2 + 20);
  endtask

  initial begin
    cur    = -1;
    rst    = 1'b0;
    s      = 1'b0;
    opcode = 3'b000;
    op     = 2'b00;
    for (int g = 0; g < NCFG; g++) begin
      start_cfg(g);
      do_instr(g, 3'b101, 2'b00);
      do_instr(g, 3'b101, 2'b01);
      do_instr(g, 3'b101, 2'b11);
      do_instr(g, 3'b100, 2'b00);
      do_instr(g, 3'b011, 2'b00);
      do_instr(g, 3'b110, 2'b10);
      do_instr(g, 3'b110, 2'b00);
      do_instr(g, 3'b010, 2'b01);
      repeat (12) rand_instr(g);
      reset_mid_ldr(g);
      repeat (4) rand_instr(g);
      do_halt(g);
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controller_fsm_mem.md
# controller_fsm_mem

Parametrised next-generation instruction controller for the 16-bit datapath CPU. It adds autonomous instruction fetch (PC and instruction register control), LDR/STR memory sequencing with a configurable memory read latency, HALT, and a selectable single-step mode. All outputs are fully specified; no don't-cares. The block sits between the instruction register decoder, the datapath (register file, A/B/C, ALU, status), the PC/address registers and the memory interface.

## Interface
- MEM_LAT, 1: memory read latency (≥1), in consecutive READ cycles before mdata is valid.
- SINGLE_STEP, 0: 1 parks in WAIT after each instruction until `s`; 0 free-runs.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- s  in  1  step request (used only when SINGLE_STEP=1, sampled in WAIT).
- opcode  in  3  IR[15:13].
- op  in  2  IR[12:11].
- w  out  1  1 in WAIT and HALT.
- write, loada, loadb, loadc, loads  out  1  datapath strobes.
- asel, bsel  out  1  ALU source selects (asel=1: A input zero; bsel=1: sximm5).
- nsel  out  3  one-hot register select: 100 Rn, 010 Rd, 001 Rm; 000 when unused.
- vsel  out  4  one-hot writeback source: 0001 C, 0010 PC, 0100 sximm8, 1000 mdata; 0000 when write=0.
- load_ir, load_pc, reset_pc, load_addr, addr_sel  out  1  fetch/address control (addr_sel=1: memory address from PC).
- mem_cmd  out  2  00 none, 01 READ, 10 WRITE.

## Operation
- Moore outputs from the state and the latency counter; asel in EXEC also depends on opcode. All unlisted outputs are 0 in every state.
- Latency counter `cnt` (width $clog2(MEM_LAT+1)) clears on entry to IF/MRD and increments each cycle in them.
- States and outputs:
  - RST: reset_pc=1, load_pc=1. Next: WAIT if SINGLE_STEP, else IF.
  - WAIT: w=1. Next: IF when s=1, otherwise hold.
  - IF: addr_sel=1, mem_cmd=01, with load_ir=1 when cnt==MEM_LAT-1. Next: UPDPC after MEM_LAT cycles.
  - UPDPC: load_pc=1. Next: DECODE.
  - DECODE: no outputs. Dispatch:
    - 101/op≠11 → GETA.
    - 101/11 (MVN) → GETB, skipping GETA.
    - 110/10 → WIMM.
    - 110/00 → GETB.
    - 011/00 (LDR) and 100/00 (STR) → GETA.
    - 111 → HALT.
    - Any other encoding is a NOP and goes to DONE target.
  - GETA: nsel=100, loada=1. Next: GETB for ALU, ADDR for LDR/STR.
  - GETB: nsel=001, loadb=1. Next: CMP if 101/01, else EXEC.
  - EXEC: loadc=1, asel=(opcode==110), bsel=0. Next: WRC.
  - WRC: nsel=010, vsel=0001, write=1. Next: DONE.
  - CMP: loads=1, asel=0, bsel=0. Next: DONE.
  - WIMM: nsel=100, vsel=0100, write=1. Next: DONE.
  - ADDR: asel=0, bsel=1, loadc=1. Next: LDADDR.
  - LDADDR: load_addr=1. Next: MRD (LDR) or GETD (STR).
  - MRD: addr_sel=0, mem_cmd=01; on cnt==MEM_LAT-1 also nsel=010, vsel=1000, write=1. Next: DONE after MEM_LAT cycles.
  - GETD: nsel=010, loadb=1. Next: PASSD.
  - PASSD: asel=1, bsel=0, loadc=1. Next: MWR.
  - MWR: addr_sel=0, mem_cmd=10 for one cycle. Next: DONE.
  - HALT: w=1. Holds until reset; s is ignored.
- DONE target = WAIT if SINGLE_STEP=1, else IF.

## Timing
- reset=1 at a rising edge puts the block in RST next cycle, from any state; in-flight memory commands are abandoned and cnt is cleared. While reset is held, outputs are the RST values (reset_pc=1, load_pc=1, all others 0).
- Cycles per instruction = fetch overhead (MEM_LAT+2) plus path length:
  - ADD/AND: 4
  - CMP: 3
  - MVN: 3
  - MOV imm: 1
  - MOV reg: 3
  - LDR: 3+MEM_LAT
  - STR: 6
- mem_cmd READ is held for exactly MEM_LAT consecutive cycles with a stable addr_sel; it is never interrupted except by reset.
- When s=1 arrives in any state other than WAIT, it is ignored (no queuing).

## Test plan
- MEM_LAT=1, SINGLE_STEP=0, release reset, IR=ADD (101/00) → RST, IF(load_ir), UPDPC, DECODE, GETA(nsel=100), GETB(nsel=001), EXEC, WRC(vsel=0001, nsel=010, write) → back in IF on cycle 8.
- MEM_LAT=3 → mem_cmd=01 and addr_sel=1 for exactly 3 cycles, with load_ir only on the 3rd; LDR holds the MRD read for 3 cycles and write=1, vsel=1000 only on the last.
- CMP (101/01) → loads=1 for one cycle with loadc=0 and write never asserted; MVN (101/11) → no GETA cycle (loada never asserted).
- STR (100/00) → ADDR(bsel=1, loadc), LDADDR(load_addr), GETD(nsel=010), PASSD(asel=1), then a single mem_cmd=10 cycle with addr_sel=0.
- SINGLE_STEP=1 → w=1 after reset and after each instruction; a 1-cycle s pulse starts exactly one fetch; s during EXEC has no effect.
- HALT (111) → w=1 held for 20 cycles despite s pulses; reset mid-LDR (during MRD) → RST next cycle, with mem_cmd=00 and reset_pc=1.
